// File: rtl/lzd_ctrl_pkg.sv
// Shared definitions for the LZD shift controller: FSM state encodings.
package lzd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

endpackage : lzd_ctrl_pkg

// File: rtl/gate_cells.sv
// Primitive two-input / one-input gate cells used to build structural logic.
module And (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule : And

module Or (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule : Or

module Xor (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ^ b_i;
endmodule : Xor

module Not (
  input  logic a_i,
  output logic y_o
);
  assign y_o = ~a_i;
endmodule : Not

// File: rtl/param_is_less_than.sv
// Unsigned comparator a < b (or a <= b when INCLUSIVE != 0), built from gate
// cells as an MSB-first cascade. Each stage carries "less so far" and
// "equal so far"; a lower bit can only decide the result while all higher
// bits are still equal.
module param_is_less_than #(
  parameter int WIDTH     = 4,
  parameter int INCLUSIVE = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             lt_o
);

  localparam logic INCL_BIT = (INCLUSIVE != 0) ? 1'b1 : 1'b0;

  // Stage k handles bit WIDTH-1-k, so stage 0 is the MSB.
  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    localparam int BIT = WIDTH - 1 - k;
    logic lt_in_s, eq_in_s;
    logic diff_s, eq_bit_s, na_s, lt_bit_s, step_s;
    logic lt_s, eq_s;

    if (k == 0) begin : g_seed
      assign lt_in_s = 1'b0;
      assign eq_in_s = 1'b1;
    end else begin : g_chain
      assign lt_in_s = g_stage[k-1].lt_s;
      assign eq_in_s = g_stage[k-1].eq_s;
    end

    Xor u_diff  (.a_i(a_i[BIT]), .b_i(b_i[BIT]), .y_o(diff_s));
    Not u_eqb   (.a_i(diff_s),   .y_o(eq_bit_s));
    Not u_na    (.a_i(a_i[BIT]), .y_o(na_s));
    And u_ltb   (.a_i(na_s),     .b_i(b_i[BIT]), .y_o(lt_bit_s));
    And u_step  (.a_i(eq_in_s),  .b_i(lt_bit_s), .y_o(step_s));
    Or  u_lt    (.a_i(lt_in_s),  .b_i(step_s),   .y_o(lt_s));
    And u_eq    (.a_i(eq_in_s),  .b_i(eq_bit_s), .y_o(eq_s));
  end

  logic incl_eq_s;

  // Equality only contributes to the result in the inclusive variant.
  And u_incl (.a_i(g_stage[WIDTH-1].eq_s), .b_i(INCL_BIT), .y_o(incl_eq_s));
  Or  u_fin  (.a_i(g_stage[WIDTH-1].lt_s), .b_i(incl_eq_s), .y_o(lt_o));

endmodule : param_is_less_than

// File: rtl/lzd_shift_controller.sv
// Shift sequencer driven by a leading-zero-detector result: issues one
// shift_en per cycle until the shift count reaches the latched target,
// then pulses done for one cycle and returns to IDLE.
module lzd_shift_controller
  import lzd_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int INCLUSIVE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             clear,
  output logic             ready,
  output logic             shift_en,
  output logic [WIDTH:0]   count,
  output logic             done
);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH:0]   count_q, count_d;
  logic [WIDTH:0]   target_q, target_d;
  logic [WIDTH:0]   target_ext_s;
  logic [WIDTH:0]   count_inc_s;
  logic             cmp_start_s;
  logic             cmp_next_s;

  // The counter is one bit wider than target so it can reach 2^WIDTH.
  assign target_ext_s = {1'b0, target};
  assign count_inc_s  = count_q + {{WIDTH{1'b0}}, 1'b1};

  // Decides at accept time whether any shift is needed at all.
  param_is_less_than #(.WIDTH(WIDTH + 1), .INCLUSIVE(INCLUSIVE)) u_cmp_start (
    .a_i  ({(WIDTH + 1){1'b0}}),
    .b_i  (target_ext_s),
    .lt_o (cmp_start_s)
  );

  // Decides whether the shift issued this cycle is the last one.
  param_is_less_than #(.WIDTH(WIDTH + 1), .INCLUSIVE(INCLUSIVE)) u_cmp_next (
    .a_i  (count_inc_s),
    .b_i  (target_q),
    .lt_o (cmp_next_s)
  );

  // State, counter and latched target registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= {(WIDTH + 1){1'b0}};
      target_q <= {(WIDTH + 1){1'b0}};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
    end
  end

  // Next-state logic; clear overrides every transition including start.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    if (clear) begin
      state_d = IDLE;
      count_d = {(WIDTH + 1){1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            target_d = target_ext_s;
            count_d  = {(WIDTH + 1){1'b0}};
            state_d  = cmp_start_s ? SHIFT : DONE;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          count_d = count_inc_s;
          if (cmp_next_s) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          count_d = {(WIDTH + 1){1'b0}};
        end
      endcase
    end
  end

  assign ready    = (state_q == IDLE);
  assign shift_en = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign count    = count_q;

endmodule : lzd_shift_controller

// File: tb/tb_lzd_shift_controller.sv
// Directed bench for lzd_shift_controller: two instances (exclusive and
// inclusive compare) driven in parallel, plus an exhaustive comparator sweep.
module tb_lzd_shift_controller;

  logic       clk = 1'b0;
  logic       rst, start, clear;
  logic [3:0] target;
  logic       ready0, shift_en0, done0;
  logic       ready1, shift_en1, done1;
  logic [4:0] count0, count1;
  logic [3:0] ca, cb;
  logic       lt0, lt1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int tgt;
    int sh0;
    int sh1;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  lzd_shift_controller #(.WIDTH(4), .INCLUSIVE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .target(target), .clear(clear),
    .ready(ready0), .shift_en(shift_en0), .count(count0), .done(done0)
  );

  lzd_shift_controller #(.WIDTH(4), .INCLUSIVE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .target(target), .clear(clear),
    .ready(ready1), .shift_en(shift_en1), .count(count1), .done(done1)
  );

  param_is_less_than #(.WIDTH(4), .INCLUSIVE(0)) cmp0 (.a_i(ca), .b_i(cb), .lt_o(lt0));
  param_is_less_than #(.WIDTH(4), .INCLUSIVE(1)) cmp1 (.a_i(ca), .b_i(cb), .lt_o(lt1));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One sequence on both instances; expectations e0 (exclusive) and e1 (inclusive).
  task automatic run_vec(input int t, input int e0, input int e1);
    int sh0 = 0, sh1 = 0, dc0 = 0, dc1 = 0, nd0 = 0, nd1 = 0, cd0 = -1, cd1 = -1;
    @(negedge clk);
    start  = 1'b1;
    target = 4'(t);
    @(negedge clk);
    start  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (shift_en0) sh0++;
      if (shift_en1) sh1++;
      if (done0) begin nd0++; if (dc0 == 0) begin dc0 = c; cd0 = int'(count0); end end
      if (done1) begin nd1++; if (dc1 == 0) begin dc1 = c; cd1 = int'(count1); end end
      @(negedge clk);
    end
    chk($sformatf("t%0d_shifts_x", t), sh0, e0);
    chk($sformatf("t%0d_latency_x", t), dc0, e0 + 1);
    chk($sformatf("t%0d_done_width_x", t), nd0, 1);
    chk($sformatf("t%0d_count_x", t), cd0, e0);
    chk($sformatf("t%0d_count_hold_x", t), int'(count0), e0);
    chk($sformatf("t%0d_shifts_i", t), sh1, e1);
    chk($sformatf("t%0d_latency_i", t), dc1, e1 + 1);
    chk($sformatf("t%0d_done_width_i", t), nd1, 1);
    chk($sformatf("t%0d_count_i", t), cd1, e1);
    chk($sformatf("t%0d_count_hold_i", t), int'(count1), e1);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  initial begin
    int sh, seen, nd;

    vecs[0] = '{tgt: 5,  sh0: 5,  sh1: 6};
    vecs[1] = '{tgt: 0,  sh0: 0,  sh1: 1};
    vecs[2] = '{tgt: 15, sh0: 15, sh1: 16};
    vecs[3] = '{tgt: 1,  sh0: 1,  sh1: 2};
    vecs[4] = '{tgt: 8,  sh0: 8,  sh1: 9};
    vecs[5] = '{tgt: 14, sh0: 14, sh1: 15};

    rst = 1'b0; start = 1'b0; clear = 1'b0; target = 4'd0; ca = 4'd0; cb = 4'd0;
    #1 rst = 1'b1;
    #2;
    chk("reset_ready", int'(ready0), 1);
    chk("reset_count", int'(count0), 0);
    chk("reset_shift_en", int'(shift_en0), 0);
    chk("reset_done", int'(done0), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i].tgt, vecs[i].sh0, vecs[i].sh1);

    // Start while busy is ignored; start right after done is accepted.
    @(negedge clk);
    start = 1'b1; target = 4'd3;
    @(negedge clk);
    target = 4'd9;
    sh = 0; seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (shift_en0) sh++;
      if (done0) begin seen = 1; start = 1'b0; end
      else @(negedge clk);
    end
    chk("busy_done_seen", seen, 1);
    chk("busy_shifts", sh, 3);
    chk("busy_count", int'(count0), 3);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_ready", int'(ready0), 1);
    start = 1'b1; target = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept_shift", int'(shift_en0), 1);
    chk("b2b_accept_count", int'(count0), 0);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (done0) seen = 1;
      else @(negedge clk);
    end
    chk("b2b_done_seen", seen, 1);
    chk("b2b_count", int'(count0), 2);
    idle_cycles(30);

    // Synchronous clear after two shifts.
    start = 1'b1; target = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("clr_pre_shift", int'(shift_en0), 1);
    chk("clr_pre_count", int'(count0), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_ready", int'(ready0), 1);
    chk("clr_count", int'(count0), 0);
    chk("clr_shift_en", int'(shift_en0), 0);
    chk("clr_done", int'(done0), 0);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (done0) nd++;
      @(negedge clk);
    end
    chk("clr_no_done", nd, 0);

    // Asynchronous reset in the middle of a shift sequence.
    start = 1'b1; target = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", int'(ready0), 1);
    chk("arst_count", int'(count0), 0);
    chk("arst_shift_en", int'(shift_en0), 0);
    chk("arst_done", int'(done0), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (done0) nd++;
      @(negedge clk);
    end
    chk("arst_no_done", nd, 0);
    run_vec(3, 3, 4);

    // Exhaustive comparator sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ca = 4'(a); cb = 4'(b);
        #1;
        chk($sformatf("cmp_lt_%0d_%0d", a, b), int'(lt0), (a < b) ? 1 : 0);
        chk($sformatf("cmp_le_%0d_%0d", a, b), int'(lt1), (a <= b) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lzd_shift_controller

// File: doc/lzd_shift_controller.md
LZD_SHIFT_CONTROLLER -- requirements
Module: lzd_shift_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the target shift amount.
REQ-002 SHALL have parameter INCLUSIVE, default 0: 0 = shift while count < target; 1 = shift while count <= target.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to begin a shift sequence; qualified by ready.
REQ-006 SHALL have port target, input, WIDTH: shift amount (LZD output); sampled only on accepted start.
REQ-007 SHALL have port clear, input, 1: synchronous abort; returns the block to IDLE.
REQ-008 SHALL have port ready, output, 1: high only in IDLE.
REQ-009 SHALL have port shift_en, output, 1: enables one datapath shift per cycle.
REQ-010 SHALL have port count, output, WIDTH+1: number of shifts issued in the current or last sequence.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only when start=1 and ready=1: latch target zero-extended to WIDTH+1 and clear count to 0.
REQ-014 On accept, SHALL go to SHIFT if cmp(0, target) is true, else to DONE; cmp is < (INCLUSIVE=0) or <= (INCLUSIVE=1).
REQ-015 In SHIFT, SHALL drive shift_en=1 (combinational from state) and increment count by 1 each cycle.
REQ-016 SHALL leave SHIFT for DONE in the cycle where cmp(count+1, target) is false; otherwise SHALL stay in SHIFT.
REQ-017 SHALL produce exactly target shift_en cycles when INCLUSIVE=0 and target+1 when INCLUSIVE=1; total start-to-done latency = shifts + 1 cycles.
REQ-018 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE; count SHALL hold its final value until the next accepted start.
REQ-019 SHALL ignore start while busy (SHIFT or DONE); a target change while busy SHALL have no effect.
REQ-020 SHALL give clear priority over start and over all state transitions; next state IDLE, count=0, no done pulse.
REQ-021 SHALL accept start in the IDLE cycle directly after DONE; back-to-back sequences are legal.
REQ-022 SHALL never wrap count: the WIDTH+1-bit counter covers target = 2^WIDTH-1 with INCLUSIVE=1.
REQ-023 SHALL perform all comparisons unsigned, via the comparator sub-module.

Reset
REQ-024 On rst=1, SHALL go immediately (asynchronously) to IDLE with count=0, latched target=0, shift_en=0, done=0, ready=1.
REQ-025 Reset asserted mid-SHIFT SHALL abort the sequence without a done pulse; the first start after reset release SHALL be accepted normally.

Structure
REQ-026 SHALL take its state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) from the shared package lzd_ctrl_pkg.
REQ-027 SHALL implement the compare in one sub-module, param_is_less_than (parameters WIDTH, INCLUSIVE), built from the existing And/Or/Xor/Not gate cells as an MSB-first cascade.

Verification
REQ-028 WIDTH=4, INCLUSIVE=0, start with target=5 -> shift_en high 5 consecutive cycles, done pulse on cycle 6, count=5.
REQ-029 target=0, INCLUSIVE=0 -> no shift_en, done one cycle after start, count=0; with INCLUSIVE=1 -> exactly 1 shift_en cycle.
REQ-030 WIDTH=4, INCLUSIVE=1, target=15 -> 16 shift_en cycles, count=16, no wrap.
REQ-031 start with target=9 while in SHIFT from target=3 -> ignored; 3 shifts, count=3; a start in the cycle after done is accepted.
REQ-032 Assert clear after 2 shifts of target=7 -> IDLE next cycle, count=0, no done; async rst mid-SHIFT -> outputs at reset values before the next edge.
REQ-033 Exhaustive param_is_less_than check, WIDTH=4, all 256 pairs for both INCLUSIVE values -> matches the integer compare.
